// File: rtl/ppu_reg_port_pkg.sv
// Shared definitions for the PPU CPU-side register port: register offsets,
// access FSM encodings and PPUSTATUS bit layout.
package ppu_reg_port_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VRD  = 2'd1;
    localparam logic [1:0] ST_VWR  = 2'd2;

    localparam int unsigned STAT_VBLANK = 7;
    localparam int unsigned STAT_SPR0   = 6;
    localparam int unsigned STAT_OVF    = 5;

    localparam logic [13:0] PAL_BASE_DEF = 14'h3F00;

    function automatic logic [7:0] status_byte(input logic       vb,
                                               input logic       s0,
                                               input logic       ov,
                                               input logic [4:0] ob);
        logic [7:0] s;
        s              = {3'b000, ob};
        s[STAT_VBLANK] = vb;
        s[STAT_SPR0]   = s0;
        s[STAT_OVF]    = ov;
        return s;
    endfunction

endpackage

// File: rtl/ppu_loopy_regs.sv
// Scroll/address latches: temporary address t, current address v, fine X
// and the shared first/second write toggle w.
module ppu_loopy_regs
    import ppu_reg_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        status_rd,
    input  logic        v_inc,
    input  logic        inc32,
    output logic [14:0] t_reg,
    output logic [14:0] v_reg,
    output logic [2:0]  fine_x
);

    logic w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_reg  <= '0;
            v_reg  <= '0;
            fine_x <= '0;
            w      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_sel)
                    REG_CTRL: t_reg[11:10] <= wr_data[1:0];
                    REG_SCROLL: begin
                        if (!w) begin
                            t_reg[4:0] <= wr_data[7:3];
                            fine_x     <= wr_data[2:0];
                            w          <= 1'b1;
                        end else begin
                            t_reg[14:12] <= wr_data[2:0];
                            t_reg[9:5]   <= wr_data[7:3];
                            w            <= 1'b0;
                        end
                    end
                    REG_ADDR: begin
                        if (!w) begin
                            t_reg[13:8] <= wr_data[5:0];
                            t_reg[14]   <= 1'b0;
                            w           <= 1'b1;
                        end else begin
                            t_reg[7:0] <= wr_data;
                            v_reg      <= {t_reg[14:8], wr_data};
                            w          <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (status_rd)
                w <= 1'b0;
            // Increments only fire on VRAM ack, when no CPU access can hit.
            if (v_inc)
                v_reg <= v_reg + (inc32 ? 15'd32 : 15'd1);
        end
    end

endmodule

// File: rtl/ppu_reg_port.sv
// CPU-side responder for the PPU register window 0x2000-0x2007: control
// registers, status flags, OAM port and the stalling PPUDATA path to VRAM.
module ppu_reg_port
    import ppu_reg_port_pkg::*;
#(
    parameter logic [15:0] REG_BASE = 16'h2000,
    parameter logic [13:0] PAL_BASE = PAL_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_in,
    input  logic        addr_valid,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic        vram_wr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    input  logic        vram_ack,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,
    input  logic        vblank_set,
    input  logic        frame_clr,
    input  logic        spr0_set,
    input  logic        ovf_set,
    output logic [7:0]  ctrl_reg,
    output logic [7:0]  mask_reg,
    output logic [14:0] t_reg,
    output logic [14:0] v_reg,
    output logic [2:0]  fine_x,
    output logic        nmi_out
);

    logic [1:0] state;
    logic       vblank;
    logic       spr0_hit;
    logic       spr_ovf;
    logic [7:0] open_bus;
    logic [7:0] rd_buf;

    logic       hit;
    logic       wr_hit;
    logic       rd_hit;
    logic [2:0] sel;
    logic       status_rd;
    logic       ack_done;
    logic       pal_hit;
    logic [7:0] status_val;
    logic [7:0] reg_rd_val;
    logic [7:0] vram_rd_val;

    assign sel       = addr_in[2:0];
    assign hit       = (cpu_rd | cpu_wr) & ~addr_valid
                       & (addr_in[15:3] == REG_BASE[15:3]) & cpu_rdy;
    assign wr_hit    = hit & cpu_wr;
    assign rd_hit    = hit & cpu_rd & ~cpu_wr;
    assign status_rd = rd_hit & (sel == REG_STATUS);
    assign ack_done  = vram_ack & (state != ST_IDLE);

    assign cpu_rdy   = (state == ST_IDLE);
    assign vram_rd   = (state == ST_VRD);
    assign vram_wr   = (state == ST_VWR);
    assign vram_addr = v_reg[13:0];
    assign nmi_out   = ctrl_reg[7] & vblank;

    // A vblank_set landing on the status read is reported as clear.
    assign status_val  = status_byte(vblank & ~vblank_set, spr0_hit, spr_ovf, open_bus[4:0]);
    assign pal_hit     = ({1'b0, PAL_BASE} <= v_reg);
    assign vram_rd_val = pal_hit ? vram_rdata : rd_buf;

    always_comb begin
        reg_rd_val = open_bus;
        case (sel)
            REG_STATUS:  reg_rd_val = status_val;
            REG_OAMDATA: reg_rd_val = oam_rdata;
            default:     reg_rd_val = open_bus;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_hit && sel == REG_DATA)
                        state <= ST_VWR;
                    else if (rd_hit && sel == REG_DATA)
                        state <= ST_VRD;
                end
                ST_VRD, ST_VWR: begin
                    if (vram_ack)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg   <= '0;
            mask_reg   <= '0;
            oam_addr   <= '0;
            oam_we     <= 1'b0;
            oam_wdata  <= '0;
            vram_wdata <= '0;
            open_bus   <= '0;
            cpu_rdata  <= '0;
            rd_buf     <= '0;
        end else begin
            oam_we <= 1'b0;
            if (wr_hit) begin
                open_bus <= cpu_wdata;
                case (sel)
                    REG_CTRL:    ctrl_reg <= cpu_wdata;
                    REG_MASK:    mask_reg <= cpu_wdata;
                    REG_OAMADDR: oam_addr <= cpu_wdata;
                    REG_OAMDATA: begin
                        oam_we    <= 1'b1;
                        oam_wdata <= cpu_wdata;
                        oam_addr  <= oam_addr + 8'd1;
                    end
                    REG_DATA:    vram_wdata <= cpu_wdata;
                    default: ;
                endcase
            end
            if (rd_hit && sel != REG_DATA) begin
                cpu_rdata <= reg_rd_val;
                open_bus  <= reg_rd_val;
            end
            if (state == ST_VRD && vram_ack) begin
                cpu_rdata <= vram_rd_val;
                open_bus  <= vram_rd_val;
                rd_buf    <= vram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblank   <= 1'b0;
            spr0_hit <= 1'b0;
            spr_ovf  <= 1'b0;
        end else if (frame_clr) begin
            vblank   <= 1'b0;
            spr0_hit <= 1'b0;
            spr_ovf  <= 1'b0;
        end else begin
            if (status_rd)
                vblank <= 1'b0;
            else if (vblank_set)
                vblank <= 1'b1;
            if (spr0_set)
                spr0_hit <= 1'b1;
            if (ovf_set)
                spr_ovf <= 1'b1;
        end
    end

    ppu_loopy_regs u_loopy (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_hit),
        .wr_sel    (sel),
        .wr_data   (cpu_wdata),
        .status_rd (status_rd),
        .v_inc     (ack_done),
        .inc32     (ctrl_reg[2]),
        .t_reg     (t_reg),
        .v_reg     (v_reg),
        .fine_x    (fine_x)
    );

endmodule

// File: tb/tb_ppu_reg_port.sv
// Directed bench for ppu_reg_port: register writes, scroll/address latches,
// stalled PPUDATA accesses, status flags, OAM port and async reset.
module tb_ppu_reg_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr_in = '0;
    logic        addr_valid = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = '0;
    logic        vram_ack = 1'b0;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata = '0;
    logic        vblank_set = 1'b0;
    logic        frame_clr = 1'b0;
    logic        spr0_set = 1'b0;
    logic        ovf_set = 1'b0;
    logic [7:0]  ctrl_reg;
    logic [7:0]  mask_reg;
    logic [14:0] t_reg;
    logic [14:0] v_reg;
    logic [2:0]  fine_x;
    logic        nmi_out;

    int checks = 0;
    int errors = 0;
    int lowcnt = 0;
    logic [7:0] d;

    ppu_reg_port #(.REG_BASE(16'h2000), .PAL_BASE(14'h3F00)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .oam_rdata(oam_rdata), .vblank_set(vblank_set), .frame_clr(frame_clr),
        .spr0_set(spr0_set), .ovf_set(ovf_set), .ctrl_reg(ctrl_reg),
        .mask_reg(mask_reg), .t_reg(t_reg), .v_reg(v_reg), .fine_x(fine_x),
        .nmi_out(nmi_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
        addr_in = a; cpu_wdata = v; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
        addr_in = a; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        v = cpu_rdata;
    endtask

    // Counts stalled cycles; ack is sampled 'delay' cycles after the first stall.
    task automatic vram_xfer(input int delay, input logic [7:0] rv);
        lowcnt = 0;
        for (int i = 0; i <= delay; i++) begin
            if (!cpu_rdy) lowcnt++;
            if (i == delay) begin
                vram_ack = 1'b1; vram_rdata = rv;
            end
            @(negedge clk);
        end
        vram_ack = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: vblank_set = 1'b1;
            1: frame_clr = 1'b1;
            2: spr0_set = 1'b1;
            default: ovf_set = 1'b1;
        endcase
        @(negedge clk);
        vblank_set = 1'b0; frame_clr = 1'b0; spr0_set = 1'b0; ovf_set = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rst_v", {1'b0, v_reg}, 16'h0000);
        chk("rst_rdata", {8'd0, cpu_rdata}, 16'h0000);
        chk("rst_vrd", {15'd0, vram_rd}, 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // Address latch and w reset through a status read
        cpu_write(16'h2006, 8'h21);
        chk("t_hi", {1'b0, t_reg}, 16'h2100);
        cpu_read(16'h2002, d);
        chk("stat_ob", {8'd0, d}, 16'h0001);
        cpu_write(16'h2006, 8'h21);
        cpu_write(16'h2006, 8'h08);
        chk("v_2108", {1'b0, v_reg}, 16'h2108);

        // Non-hit is ignored
        addr_valid = 1'b1;
        cpu_write(16'h2000, 8'hFF);
        addr_valid = 1'b0;
        chk("nohit_ctrl", {8'd0, ctrl_reg}, 16'h0000);

        cpu_write(16'h2005, 8'h7D);
        cpu_write(16'h2005, 8'h5E);
        chk("fine_x", {13'd0, fine_x}, 16'd5);
        chk("t_scroll", {1'b0, t_reg}, 16'h616F);

        // Buffered PPUDATA read with late ack
        cpu_write(16'h2006, 8'h20);
        cpu_write(16'h2006, 8'h00);
        cpu_read(16'h2007, d);
        chk("vrd_strobe", {15'd0, vram_rd}, 16'd1);
        chk("vrd_addr", {2'b0, vram_addr}, 16'h2000);
        vram_xfer(3, 8'hAB);
        chk("vrd_stall", lowcnt[15:0], 16'd4);
        chk("vrd_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("vrd_old", {8'd0, cpu_rdata}, 16'h0000);
        chk("v_2001", {1'b0, v_reg}, 16'h2001);
        cpu_read(16'h2007, d);
        vram_xfer(0, 8'hCD);
        chk("vrd_buf", {8'd0, cpu_rdata}, 16'h00AB);

        // Palette write with +32 increment, then unbuffered palette read
        cpu_write(16'h2000, 8'h04);
        cpu_write(16'h2006, 8'h3F);
        cpu_write(16'h2006, 8'h00);
        cpu_write(16'h2007, 8'h0F);
        chk("vwr_strobe", {15'd0, vram_wr}, 16'd1);
        chk("vwr_addr", {2'b0, vram_addr}, 16'h3F00);
        chk("vwr_data", {8'd0, vram_wdata}, 16'h000F);
        vram_xfer(1, 8'h00);
        chk("vwr_drop", {15'd0, vram_wr}, 16'd0);
        chk("v_3F20", {1'b0, v_reg}, 16'h3F20);
        cpu_write(16'h2006, 8'h3F);
        cpu_write(16'h2006, 8'h10);
        cpu_read(16'h2007, d);
        vram_xfer(1, 8'h2A);
        chk("pal_rd", {8'd0, cpu_rdata}, 16'h002A);

        // vblank, NMI and read suppression
        cpu_write(16'h2000, 8'h00);
        pulse(0);
        chk("nmi_off", {15'd0, nmi_out}, 16'd0);
        cpu_write(16'h2000, 8'h80);
        chk("nmi_on", {15'd0, nmi_out}, 16'd1);
        cpu_read(16'h2002, d);
        chk("vbl_rd1", {15'd0, d[7]}, 16'd1);
        chk("nmi_clr", {15'd0, nmi_out}, 16'd0);
        cpu_read(16'h2002, d);
        chk("vbl_rd2", {15'd0, d[7]}, 16'd0);
        addr_in = 16'h2002; cpu_rd = 1'b1; vblank_set = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0; vblank_set = 1'b0;
        chk("vbl_supp", {15'd0, cpu_rdata[7]}, 16'd0);
        chk("nmi_supp", {15'd0, nmi_out}, 16'd0);
        cpu_read(16'h2002, d);
        chk("vbl_stay0", {15'd0, d[7]}, 16'd0);

        // frame_clr beats sprite-0 set
        spr0_set = 1'b1;
        pulse(1);
        cpu_read(16'h2002, d);
        chk("clr_prio", {15'd0, d[6]}, 16'd0);
        spr0_set = 1'b1;
        pulse(3);
        cpu_read(16'h2002, d);
        chk("spr_flags", {14'd0, d[6:5]}, 16'd3);
        pulse(1);
        cpu_read(16'h2002, d);
        chk("flags_clr", {13'd0, d[7:5]}, 16'd0);

        // OAM port
        cpu_write(16'h2003, 8'hFF);
        cpu_write(16'h2004, 8'h55);
        chk("oam_we", {15'd0, oam_we}, 16'd1);
        chk("oam_wdata", {8'd0, oam_wdata}, 16'h0055);
        chk("oam_wrap", {8'd0, oam_addr}, 16'h0000);
        @(negedge clk);
        chk("oam_we_drop", {15'd0, oam_we}, 16'd0);
        oam_rdata = 8'h77;
        cpu_read(16'h2004, d);
        chk("oam_rd", {8'd0, d}, 16'h0077);
        chk("oam_noinc", {8'd0, oam_addr}, 16'h0000);

        // Async reset mid-access
        cpu_read(16'h2007, d);
        chk("pre_rst_rdy", {15'd0, cpu_rdy}, 16'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_vrd", {15'd0, vram_rd}, 16'd0);
        chk("arst_rdy", {15'd0, cpu_rdy}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", {15'd0, cpu_rdy}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
